// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, min-length zero padding, underrun and bad-EOP signalling.
// Define GMII_TX_CRC_EN to append the IEEE 802.3 CRC-32 FCS after payload/pad.
module gmii_tx_framer #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_FRAME  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_srdy,
  output logic       p_drdy,
  input  logic [7:0] p_data,
  input  logic [1:0] p_code,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_er
);

  localparam logic [1:0] CODE_SOP      = 2'd1;
  localparam logic [1:0] CODE_EOP_GOOD = 2'd2;
  localparam logic [1:0] CODE_EOP_BAD  = 2'd3;

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [10:0] MIN_COUNT = 11'(MIN_FRAME);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD, DRAIN, IFG
`ifdef GMII_TX_CRC_EN
    , FCS
`endif
  } state_t;

`ifdef GMII_TX_CRC_EN
  localparam state_t POST_PAYLOAD = FCS;
`else
  localparam state_t POST_PAYLOAD = IFG;
`endif

  state_t           state;
  logic [10:0]      count;
  logic [10:0]      count_inc;
  logic [2:0]       idx;
  logic [IFG_W-1:0] ifg_cnt;
  logic             underrun;

  always_comb begin
    count_inc = (count == '1) ? count : count + 11'd1;
    // The held SOP byte opens the payload (count still 0); any later SOP is an underrun.
    underrun  = !p_srdy || (p_code == CODE_SOP && count != '0);
  end

  always_comb begin
    p_drdy = 1'b0;
    if (reset) begin
      case (state)
        IDLE:           p_drdy = (p_code != CODE_SOP);
        PAYLOAD, DRAIN: p_drdy = 1'b1;
        default:        p_drdy = 1'b0;
      endcase
    end
  end

`ifdef GMII_TX_CRC_EN
  logic [31:0] crc;
  logic [31:0] crc_data;
  logic [31:0] crc_pad;
  logic [31:0] crc_fin;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_data = crc_step(crc, p_data);
    crc_pad  = crc_step(crc, 8'h00);
    crc_fin  = ~crc;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      ifg_cnt    <= '0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      gmii_tx_er <= 1'b0;
`ifdef GMII_TX_CRC_EN
      crc        <= '1;
`endif
    end else begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      gmii_tx_er <= 1'b0;
      if (state != IFG) ifg_cnt <= '0;
      case (state)
        IDLE: begin
          if (p_srdy && p_code == CODE_SOP) begin
            state      <= PREAMBLE;
            count      <= '0;
            idx        <= '0;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
`ifdef GMII_TX_CRC_EN
            crc        <= '1;
`endif
          end
        end
        PREAMBLE: begin
          gmii_tx_en <= 1'b1;
          idx        <= idx + 3'd1;
          if (idx == 3'd6) begin
            gmii_txd <= 8'hD5;
            state    <= PAYLOAD;
          end else begin
            gmii_txd <= 8'h55;
          end
        end
        PAYLOAD: begin
          gmii_tx_en <= 1'b1;
          if (underrun) begin
            gmii_tx_er <= 1'b1;
            state      <= DRAIN;
          end else begin
            gmii_txd <= p_data;
            count    <= count_inc;
`ifdef GMII_TX_CRC_EN
            crc      <= crc_data;
`endif
            if (p_code == CODE_EOP_BAD) begin
              gmii_tx_er <= 1'b1;
              state      <= IFG;
            end else if (p_code == CODE_EOP_GOOD) begin
              idx <= '0;
              if (count_inc < MIN_COUNT) state <= PAD;
              else                       state <= POST_PAYLOAD;
            end
          end
        end
        PAD: begin
          gmii_tx_en <= 1'b1;
          count      <= count_inc;
          idx        <= '0;
`ifdef GMII_TX_CRC_EN
          crc        <= crc_pad;
`endif
          if (count_inc >= MIN_COUNT) state <= POST_PAYLOAD;
        end
`ifdef GMII_TX_CRC_EN
        FCS: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= crc_fin[{idx[1:0], 3'b000} +: 8];
          idx        <= idx + 3'd1;
          if (idx == 3'd3) state <= IFG;
        end
`endif
        DRAIN: begin
          if (p_srdy && (p_code == CODE_EOP_GOOD || p_code == CODE_EOP_BAD)) state <= IFG;
        end
        IFG: begin
          if (ifg_cnt == IFG_LAST) state <= IDLE;
          else                     ifg_cnt <= ifg_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, idle cycles with gmii_tx_en low between frames.
REQ-002 SHALL have parameter MIN_FRAME, default 60, minimum bytes before FCS; shorter frames are zero-padded.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port p_srdy, input, 1, upstream byte valid.
REQ-006 SHALL have port p_drdy, output, 1, framer accepts byte; transfer occurs when p_srdy and p_drdy are both high.
REQ-007 SHALL have port p_data, input, 8, payload byte.
REQ-008 SHALL have port p_code, input, 2, byte tag: 0 DATA, 1 SOP, 2 EOP-good, 3 EOP-bad.
REQ-009 SHALL have port gmii_tx_en, output, 1, GMII transmit enable.
REQ-010 SHALL have port gmii_txd, output, 8, GMII transmit data.
REQ-011 SHALL have port gmii_tx_er, output, 1, GMII transmit error.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG; gmii_tx_en, gmii_txd and gmii_tx_er SHALL all be registered.
REQ-013 IDLE: p_drdy SHALL be 1 when p_code != SOP and discard those bytes; p_drdy SHALL be 0 when p_srdy=1 and p_code=SOP, with transition to PREAMBLE.
REQ-014 PREAMBLE: if SOP is presented at cycle T, gmii_txd SHALL carry 0x55 in cycles T+1..T+7 and 0xD5 in T+8, with gmii_tx_en=1.
REQ-015 p_drdy SHALL be 1 in cycle T+8 and throughout PAYLOAD; a byte accepted in cycle N SHALL appear on gmii_txd in cycle N+1.
REQ-016 PAYLOAD: an 11-bit saturating counter SHALL count output bytes, cleared at SOP acceptance.
REQ-017 Underrun: if p_srdy=0 in PAYLOAD, gmii_tx_er=1 and gmii_txd=0x00 in the next cycle; the state SHALL go to DRAIN.
REQ-018 DRAIN: gmii_tx_en=0 and p_drdy=1, discarding bytes through the next EOP (either code), then the state SHALL go to IFG.
REQ-019 EOP-good accepted: if count < MIN_FRAME, the state SHALL go to PAD; otherwise to FCS (macro set) or IFG.
REQ-020 PAD: gmii_txd=0x00 and gmii_tx_en=1 until count = MIN_FRAME; p_drdy=0.
REQ-021 EOP-bad accepted: that byte SHALL be output with gmii_tx_er=1; no pad or FCS; the state SHALL go to IFG.
REQ-022 A SOP accepted in PAYLOAD SHALL be treated as underrun per REQ-017.
REQ-023 IFG: gmii_tx_en=0, p_drdy=0 for exactly IFG_CYCLES cycles, then the state SHALL go to IDLE.
REQ-024 gmii_tx_er SHALL be 0 except in the cases of REQ-017 and REQ-021.

Reset
REQ-025 While reset=0: state=IDLE, counters=0, gmii_tx_en=0, gmii_txd=0x00, gmii_tx_er=0, p_drdy=0, immediately and asynchronously.
REQ-026 Reset asserted mid-frame SHALL truncate the frame without gmii_tx_er; the first frame after release SHALL start from IDLE.

Configuration
REQ-027 With macro GMII_TX_CRC_EN defined, the FCS state SHALL append the IEEE 802.3 CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final complement) over payload plus pad, 4 bytes, least-significant byte first, gmii_tx_en=1.
REQ-028 Without GMII_TX_CRC_EN, no CRC logic and no FCS state SHALL exist; after PAYLOAD or PAD the state SHALL go directly to IFG.

Verification
REQ-029 SOP at cycle T, 64-byte good frame, no macro -> 0x55 x7 at T+1..T+7, 0xD5 at T+8, payload T+9..T+72, gmii_tx_en low T+73..T+84.
REQ-030 20-byte good frame, MIN_FRAME=60 -> 20 payload bytes then 40 bytes of 0x00, total gmii_tx_en high cycles = 68.
REQ-031 Macro set, MIN_FRAME=0, payload ASCII "123456789" -> FCS bytes 0x26, 0x39, 0xF4, 0xCB follow the last payload byte.
REQ-032 p_srdy dropped after byte 10 of a 64-byte frame -> one cycle gmii_tx_er=1 with gmii_txd=0x00; remaining 54 bytes accepted with gmii_tx_en=0; then 12 IFG cycles.
REQ-033 Frame ending with EOP-bad at byte 30 -> byte 30 output with gmii_tx_er=1, no pad, gmii_tx_en low next cycle.
REQ-034 reset=0 pulsed at payload byte 5 -> outputs zero within the same cycle; the next SOP yields a full preamble and a correct frame.
